gat_feat_readback: RTL and testbench
====================================

// Module: gat_feat_readback
// PURPOSE
//  Read-side master for the new-feature BRAM port B (byte address out, 32-bit data in).
//  On start, fetches rd_len words from word index rd_base, with wrap-around.
//  Streams them out on a valid/ready interface with full backpressure and a last flag.
//  Sits between gat_top's feat_bram read port and the host/DMA path.
// PARAMETERS
//  NEW_FEATURE_WIDTH  32           data word width
//  NEW_FEATURE_DEPTH  2708*16      feature BRAM depth, in words
//  NEW_FEATURE_ADDR_W clog2(DEPTH) word-index width
//  BRAM_LATENCY       2            cycles from addrb change to valid dout (>=1)
//  FIFO_DEPTH         BRAM_LATENCY+2  output buffer entries
// PORTS
//  clk             in   1                    clock
//  rst             in   1                    synchronous, active-high reset
//  gat_ready       in   1                    accelerator finished; start is honoured only when high
//  start           in   1                    1-cycle request pulse
//  rd_base         in   NEW_FEATURE_ADDR_W   first word index, sampled with start
//  rd_len          in   NEW_FEATURE_ADDR_W+1 word count, sampled with start
//  busy            out  1                    high from accepted start until done
//  done            out  1                    1-cycle pulse after the last beat is accepted
//  feat_bram_addrb out  NEW_FEATURE_ADDR_W+2 byte address = word_idx<<2; bits[1:0] always 0
//  feat_bram_dout  in   NEW_FEATURE_WIDTH    BRAM read data
//  m_tdata         out  NEW_FEATURE_WIDTH    stream data
//  m_tvalid        out  1                    stream valid
//  m_tready        in   1                    stream ready
//  m_tlast         out  1                    high on the final beat
// BEHAVIOUR
//  Reset values: busy=0, done=0, addrb=0, m_tvalid=0, m_tlast=0, m_tdata=0.
//    The FIFO, in-flight pipe and counters are cleared.
//  FSM:
//    IDLE -> RUN on start & gat_ready & rd_len!=0.
//    IDLE -> DONE on start & gat_ready & rd_len==0 (done pulse, no beats).
//    RUN -> DRAIN once rd_len addresses are issued.
//    DRAIN -> DONE once the last beat handshakes (m_tvalid & m_tready & m_tlast).
//    DONE -> IDLE after 1 cycle. done=1 only in DONE.
//  Start handling: start is ignored when busy or when gat_ready=0.
//    rd_len > NEW_FEATURE_DEPTH is clamped to NEW_FEATURE_DEPTH.
//  Issue rule: in RUN, one new address per cycle while (in_flight + fifo_count) < FIFO_DEPTH.
//    A BRAM_LATENCY-deep valid shift register tracks in-flight reads.
//    Returned dout is written to the FIFO when its tag exits the shift register.
//  Address wrap: the index increments by 1; when it reaches NEW_FEATURE_DEPTH-1 the next
//    index is 0 (no modulo divider).
//  addrb holds its last value when not issuing.
//  Throughput: 1 beat/cycle with m_tready held high.
//  First-beat latency: m_tvalid rises BRAM_LATENCY+1 cycles after start.
//  Stream rules: m_tdata, m_tvalid and m_tlast are registered FIFO head outputs and stay
//    stable while m_tvalid & !m_tready. m_tlast is set on the beat whose sequence
//    number == rd_len-1.
//  Simultaneous FIFO push and pop: legal; occupancy is unchanged.
//  The FIFO never overflows (issue credit rule).
//  Reset mid-operation: in-flight data is discarded, no done pulse, return to IDLE.
// CONFIGURATION
//  FEAT_RB_CHECKSUM_EN defined:
//    Adds output port checksum [31:0].
//    checksum = 32-bit wrapping sum of all accepted beats, zero-extended or truncated to 32 bits.
//    Cleared on accepted start; final value valid and held from the done pulse until the next start.
//    Reset value 0.
//  FEAT_RB_CHECKSUM_EN undefined: port and adder are absent; all other behaviour is identical.
// TESTING
//  1. BRAM word k = k+0x100. start, rd_base=0, rd_len=4, m_tready=1 ->
//     beats 0x100..0x103 on 4 consecutive cycles; tlast on 0x103; done 1 cycle later;
//     addrb = 0x0, 0x4, 0x8, 0xC.
//  2. rd_base=NEW_FEATURE_DEPTH-2, rd_len=4 ->
//     word indices DEPTH-2, DEPTH-1, 0, 1; addrb wraps to 0x0.
//  3. rd_len=64, m_tready toggling 1/0 every cycle, then held 0 for 20 cycles ->
//     no lost or duplicated beats; tdata stable while stalled; FIFO count <= FIFO_DEPTH.
//  4. start with gat_ready=0 -> no response.
//     start with rd_len=0 -> done 1 cycle, zero beats.
//     start while busy -> ignored.
//  5. rst asserted at beat 3 of rd_len=16 -> next cycle all outputs at reset values;
//     a fresh start (rd_len=2) completes cleanly.
//  6. FEAT_RB_CHECKSUM_EN: words 1, 2, 0xFFFFFFFF ->
//     checksum=0x00000002 at the done pulse.

Source files
------------

// File: rtl/gat_feat_readback.sv
// rtl/gat_feat_readback.sv - feature BRAM read-back master streaming words out with backpressure.
// Optional FEAT_RB_CHECKSUM_EN adds a 32-bit running checksum of accepted beats.
module gat_feat_readback #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_DEPTH  = 2708*16,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_LATENCY       = 2,
  parameter int FIFO_DEPTH         = BRAM_LATENCY+2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gat_ready,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W-1:0] rd_base,
  input  logic [NEW_FEATURE_ADDR_W:0]   rd_len,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
`ifdef FEAT_RB_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);
  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int LW = AW+1;
  localparam logic [LW-1:0] DEPTH_L = LW'(NEW_FEATURE_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(NEW_FEATURE_DEPTH-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [LW-1:0] len_q, len_d, iss_q, iss_d, push_cnt_q, push_cnt_d, len_clamped;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW+1:0] addrb_q, addrb_d;
  logic          avld_q, avld_d;
  logic [BRAM_LATENCY-1:0] pipe_q, pipe_d;
  logic [NEW_FEATURE_WIDTH-1:0] fdat_q [FIFO_DEPTH];
  logic [NEW_FEATURE_WIDTH-1:0] fdat_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fvld_q, fvld_d, flast_q, flast_d;
  logic start_ok, issue, issue_run, push, pop, credit_ok, found;
  int   in_flight, occ;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + AW'(1);
  endfunction

  assign len_clamped = (rd_len > DEPTH_L) ? DEPTH_L : rd_len;
  assign start_ok    = start & gat_ready & (state_q == S_IDLE);
  assign pop         = fvld_q[0] & m_tready;
  assign push        = pipe_q[BRAM_LATENCY-1];

  // Credit counts the address register, the BRAM pipe and the FIFO; a pop this cycle frees a slot.
  always_comb begin
    in_flight = int'(avld_q);
    occ       = 0;
    for (int i = 0; i < BRAM_LATENCY; i++) in_flight += int'(pipe_q[i]);
    for (int i = 0; i < FIFO_DEPTH; i++) occ += int'(fvld_q[i]);
    credit_ok = (in_flight + occ - int'(pop)) < FIFO_DEPTH;
  end

  assign issue_run = (state_q == S_RUN) & (iss_q != len_q) & credit_ok;
  assign issue     = issue_run | (start_ok & (len_clamped != '0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = (len_clamped == '0) ? S_DONE : S_RUN;
      S_RUN:   if (iss_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if (pop & flast_q[0]) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    len_d      = len_q;
    iss_d      = iss_q;
    push_cnt_d = push_cnt_q;
    idx_d      = idx_q;
    addrb_d    = addrb_q;
    avld_d     = issue;
    pipe_d[0]  = avld_q;
    for (int i = 1; i < BRAM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (start_ok) begin
      len_d      = len_clamped;
      iss_d      = (len_clamped != '0) ? LW'(1) : '0;
      push_cnt_d = '0;
      addrb_d    = {rd_base, 2'b00};
      idx_d      = wrap_inc(rd_base);
    end else if (issue_run) begin
      iss_d   = iss_q + LW'(1);
      addrb_d = {idx_q, 2'b00};
      idx_d   = wrap_inc(idx_q);
    end
    if (push) push_cnt_d = push_cnt_q + LW'(1);
  end

  // Shift-down FIFO: entry 0 is the registered stream head.
  always_comb begin
    fdat_d  = fdat_q;
    fvld_d  = fvld_q;
    flast_d = flast_q;
    found   = 1'b0;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH-1; i++) begin
        fdat_d[i]  = fdat_q[i+1];
        fvld_d[i]  = fvld_q[i+1];
        flast_d[i] = flast_q[i+1];
      end
      fvld_d[FIFO_DEPTH-1]  = 1'b0;
      flast_d[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (!found && !fvld_d[i]) begin
          fvld_d[i]  = 1'b1;
          fdat_d[i]  = feat_bram_dout;
          flast_d[i] = (push_cnt_q == len_q - LW'(1));
          found      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      iss_q      <= '0;
      push_cnt_q <= '0;
      idx_q      <= '0;
      addrb_q    <= '0;
      avld_q     <= 1'b0;
      pipe_q     <= '0;
      fvld_q     <= '0;
      flast_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fdat_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      iss_q      <= iss_d;
      push_cnt_q <= push_cnt_d;
      idx_q      <= idx_d;
      addrb_q    <= addrb_d;
      avld_q     <= avld_d;
      pipe_q     <= pipe_d;
      fvld_q     <= fvld_d;
      flast_q    <= flast_d;
      fdat_q     <= fdat_d;
    end
  end

  assign feat_bram_addrb = addrb_q;
  assign m_tdata         = fdat_q[0];
  assign m_tvalid        = fvld_q[0];
  assign m_tlast         = flast_q[0];

`ifdef FEAT_RB_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  always_comb begin
    sum_d = sum_q;
    if (start_ok) sum_d = '0;
    else if (pop) sum_d = sum_q + 32'(fdat_q[0]);
  end
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
  assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_gat_feat_readback.sv
// tb/tb_gat_feat_readback.sv - randomized self-checking bench for gat_feat_readback.
module tb_gat_feat_readback;
  localparam int W     = 32;
  localparam int DEPTH = 100;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst, gat_ready, start, m_tready;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;
  logic          busy, done, m_tvalid, m_tlast;
  logic [AW+1:0] addrb;
  logic [W-1:0]  dout, m_tdata;
`ifdef FEAT_RB_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  gat_feat_readback #(
    .NEW_FEATURE_WIDTH(W), .NEW_FEATURE_DEPTH(DEPTH), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .gat_ready(gat_ready), .start(start),
    .rd_base(rd_base), .rd_len(rd_len), .busy(busy), .done(done),
    .feat_bram_addrb(addrb), .feat_bram_dout(dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef FEAT_RB_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] bpipe [LAT];
  always @(posedge clk) begin
    bpipe[0] <= mem[addrb[AW+1:2]];
    for (int i = 1; i < LAT; i++) bpipe[i] <= bpipe[i-1];
  end
  assign dout = bpipe[LAT-1];

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [W:0] exp_q [$];
  int done_cnt = 0, beats = 0, tr_mode = 0;
  logic stall_prev = 1'b0, last_prev = 1'b0, plast;
  logic [W-1:0] pdata;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      last_prev  = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, plast, pdata});
      if (last_prev) check("done_after_last", done, 1);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", {m_tlast, m_tdata}, 0);
        else check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        beats++;
      end
      stall_prev = m_tvalid && !m_tready;
      last_prev  = m_tvalid && m_tready && m_tlast;
      pdata = m_tdata;
      plast = m_tlast;
      if (done) done_cnt++;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // mode: 0 ready high, 1 toggle, 2 random, 4 toggle then 20-cycle stall then high
  task automatic xfer(input int base, input int len, input int mode, input bit chk_addr, input bit second);
    int n, first, cyc, d0;
    logic [31:0] es;
    n  = (len > DEPTH) ? DEPTH : len;
    es = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'(i == n-1), mem[(base+i) % DEPTH]});
      es += mem[(base+i) % DEPTH];
    end
    d0 = done_cnt;
    tr_mode = (mode == 4) ? 1 : mode;
    @(posedge clk); #1;
    rd_base = AW'(base); rd_len = (AW+1)'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (chk_addr && k <= n) check("addrb", addrb, ((base+k-1) % DEPTH) * 4);
      if (first < 0 && m_tvalid) first = k;
    end
    if (mode == 0 && n > 0) check("first_beat_latency", first-1, LAT+1);
    if (second) begin
      @(posedge clk); #1;
      rd_base = '0; rd_len = 3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      if (mode == 4) tr_mode = (cyc < 30) ? 1 : (cyc < 50) ? 3 : 0;
    end
    check("done_seen", done_cnt != d0, 1);
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_once", done_cnt - d0, 1);
    check("busy_low", busy, 0);
`ifdef FEAT_RB_CHECKSUM_EN
    check("checksum", checksum, es);
`endif
    tr_mode = 0;
    exp_q.delete();
  endtask

  initial begin
    int d0, b0, cyc;
    rst = 1'b1; start = 1'b0; gat_ready = 1'b1; rd_base = '0; rd_len = '0;
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k + 'h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addrb", addrb, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    xfer(0, 4, 0, 1, 0);
    xfer(DEPTH-2, 4, 0, 1, 0);
    xfer(7, 64, 4, 0, 0);

    gat_ready = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1; rd_base = 3; rd_len = 5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(negedge clk);
    check("not_ready_busy", busy, 0);
    check("not_ready_done", done_cnt - d0, 0);
    gat_ready = 1'b1;

    xfer(9, 0, 0, 0, 0);
    xfer(50, 20, 0, 0, 1);
    xfer(30, DEPTH+7, 0, 0, 0);

    for (int k = 0; k < 16; k++) exp_q.push_back({1'(k == 15), mem[20+k]});
    b0 = beats;
    @(posedge clk); #1; rd_base = 20; rd_len = 16; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (beats - b0 < 3 && cyc < 200) begin @(posedge clk); cyc++; end
    check("reached_beat3", beats - b0 >= 3, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_addrb", addrb, 0);
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_tlast", m_tlast, 0);
    check("midrst_tdata", m_tdata, 0);
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    xfer(5, 2, 0, 0, 0);

    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    repeat (8) xfer($urandom_range(0, DEPTH-1), $urandom_range(1, 70), $urandom_range(0, 2), 0, 0);

`ifdef FEAT_RB_CHECKSUM_EN
    mem[10] = 32'h1; mem[11] = 32'h2; mem[12] = 32'hFFFF_FFFF;
    xfer(10, 3, 0, 0, 0);
    check("checksum_wrap", checksum, 32'h2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
